apb_event_edge_capture: RTL and testbench

Upstream conditioning stage for the APB event unit. It takes up to 32 asynchronous level-type event/interrupt lines from peripherals and synchronizes them into HCLK. It detects per-line programmable rising and/or falling edges and emits single-cycle pulses that drive the event unit's `irq_i`/`event_i` inputs. It also keeps sticky status and overrun flags that software reads over APB.

---
 rtl/apb_event_edge_pkg.sv | 24 ++
 rtl/event_sync_edge.sv | 30 +++
 rtl/apb_event_edge_capture.sv | 108 ++++++++++
 tb/tb_apb_event_edge_capture.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_event_edge_pkg.sv
// Shared definitions for the APB edge-capture block.
// Includes register offsets, the warm-up terminal count and the per-line edge selection.
package apb_event_edge_pkg;

  localparam logic [1:0] EDGE_RISE_EN = 2'd0;
  localparam logic [1:0] EDGE_FALL_EN = 2'd1;
  localparam logic [1:0] EDGE_STATUS  = 2'd2;
  localparam logic [1:0] EDGE_OVERRUN = 2'd3;

  localparam logic [1:0] WARMUP_DONE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_t;

  function automatic logic edge_match(input edge_sel_t sel, input logic rise, input logic fall);
    return (rise && (sel == EDGE_RISE || sel == EDGE_BOTH)) ||
           (fall && (sel == EDGE_FALL || sel == EDGE_BOTH));
  endfunction

endpackage

// File: rtl/event_sync_edge.sv
// Single event line: a two-flop synchronizer followed by a history flop.
// Rise and fall are combinational from the synchronized level and its previous value.
module event_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic evt_async,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= evt_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/apb_event_edge_capture.sv
// Converts asynchronous event levels into single-cycle edge pulses.
// Sticky STATUS and OVERRUN flags are readable and clearable over APB.
module apb_event_edge_capture
  import apb_event_edge_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_LINES      = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_LINES-1:0]      evt_async_i,
  output logic [NUM_LINES-1:0]      evt_o
);

  logic [NUM_LINES-1:0] rise_en;
  logic [NUM_LINES-1:0] fall_en;
  logic [NUM_LINES-1:0] status;
  logic [NUM_LINES-1:0] overrun;
  logic [NUM_LINES-1:0] hit;
  logic [NUM_LINES-1:0] clr_status;
  logic [NUM_LINES-1:0] clr_overrun;
  logic [NUM_LINES-1:0] wr_data;
  logic [1:0]           warm_cnt;
  logic [1:0]           reg_sel;
  logic                 armed;
  logic                 wr_en;
  logic [31:0]          rd_word;
  logic                 unused_addr;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  assign reg_sel     = PADDR[3:2];
  assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:4], PADDR[1:0]};
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign wr_data     = PWDATA[NUM_LINES-1:0];
  assign armed       = (warm_cnt == WARMUP_DONE);

  assign clr_status  = (wr_en && reg_sel == EDGE_STATUS)  ? wr_data : '0;
  assign clr_overrun = (wr_en && reg_sel == EDGE_OVERRUN) ? wr_data : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
      logic      rise;
      logic      fall;
      edge_sel_t sel;

      event_sync_edge u_sync (
        .clk       (HCLK),
        .rst       (HRESET),
        .evt_async (evt_async_i[gi]),
        .rise      (rise),
        .fall      (fall)
      );

      assign sel     = edge_sel_t'({fall_en[gi], rise_en[gi]});
      assign hit[gi] = armed & edge_match(sel, rise, fall);
    end
  endgenerate

  // A new hit always wins over a same-cycle clear; an edge that races a
  // STATUS clear is treated as the first edge, not an overrun.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      warm_cnt <= 2'd0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      overrun  <= '0;
      evt_o    <= '0;
    end else begin
      if (!armed) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
      evt_o   <= hit;
      status  <= hit | (status & ~clr_status);
      overrun <= (hit & status & ~clr_status) | (overrun & ~clr_overrun);
      if (wr_en && reg_sel == EDGE_RISE_EN) begin
        rise_en <= wr_data;
      end
      if (wr_en && reg_sel == EDGE_FALL_EN) begin
        fall_en <= wr_data;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      EDGE_RISE_EN: rd_word[NUM_LINES-1:0] = rise_en;
      EDGE_FALL_EN: rd_word[NUM_LINES-1:0] = fall_en;
      EDGE_STATUS:  rd_word[NUM_LINES-1:0] = status;
      default:      rd_word[NUM_LINES-1:0] = overrun;
    endcase
  end

  assign PRDATA = PSEL ? rd_word : 32'h0;

endmodule

// File: tb/tb_apb_event_edge_capture.sv
// Directed bench for apb_event_edge_capture: expected pulses are queued at stimulus
// time and matched against evt_o; register reads are compared inline.
module tb_apb_event_edge_capture;

  typedef struct packed {
    int unsigned cyc;
    logic [31:0] mask;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] evt_async;
  logic [31:0] evt;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  exp_t        q[$];

  apb_event_edge_capture #(
    .APB_ADDR_WIDTH (12),
    .NUM_LINES      (32)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PWRITE      (PWRITE),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .evt_async_i (evt_async),
    .evt_o       (evt)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Pulse expected three edges after the level is driven on this negedge.
  task automatic push_expect(input logic [31:0] mask);
    exp_t e;
    e.cyc  = cyc + 3;
    e.mask = mask;
    q.push_back(e);
  endtask

  task automatic apb_write(input logic [1:0] idx, input logic [31:0] data);
    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = {8'h00, idx, 2'b00}; PWDATA = data;
    @(negedge HCLK);
    PENABLE = 1'b1;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    $display("apb write reg=%0d data=0x%08h", idx, data);
  endtask

  task automatic apb_read(input logic [1:0] idx, input logic [31:0] exp, input string tag);
    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = {8'h00, idx, 2'b00};
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1;
    $display("apb read  reg=%0d data=0x%08h expect=0x%08h", idx, PRDATA, exp);
    check(tag, PRDATA, exp);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Release reset with a RISE_EN write landing on the first edge after release.
  task automatic release_with_rise(input logic [31:0] mask);
    @(negedge HCLK);
    HRESET = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 12'h000; PWDATA = mask;
    @(negedge HCLK);
    HRESET = 1'b0; PENABLE = 1'b1;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; evt_async = 32'hFFFF_FFFF;

    fork
      forever begin
        exp_t e;
        @(negedge HCLK);
        if (evt !== 32'h0) begin
          if (q.size() == 0) begin
            $display("pulse cyc=%0d evt=0x%08h (none expected)", cyc, evt);
            check("evt_unexpected", evt, 32'h0);
          end else begin
            e = q.pop_front();
            $display("pulse cyc=%0d evt=0x%08h expect cyc=%0d mask=0x%08h", cyc, evt, e.cyc, e.mask);
            check("evt_cycle", cyc, e.cyc);
            check("evt_mask", evt, e.mask);
          end
        end
      end
    join_none

    repeat (3) @(negedge HCLK);
    check("reset_evt", evt, 32'h0);
    check("reset_prdata_unsel", PRDATA, 32'h0);
    check("pready", {31'h0, PREADY}, 32'h1);
    check("pslverr", {31'h0, PSLVERR}, 32'h0);

    // Inputs already high at release must not produce edges during warm-up.
    release_with_rise(32'hFFFF_FFFF);
    repeat (6) @(negedge HCLK);
    apb_read(EDGE_STATUS_IDX(), 32'h0, "warmup_status");
    apb_read(2'd0, 32'hFFFF_FFFF, "warmup_rise_en");
    apb_read(2'd3, 32'h0, "warmup_overrun");
    apb_write(2'd0, 32'h0);
    @(negedge HCLK);
    evt_async = 32'h0;
    repeat (6) @(negedge HCLK);
    apb_read(2'd2, 32'h0, "no_en_status");

    // Rising edge on line 0.
    apb_write(2'd0, 32'h1);
    @(negedge HCLK);
    evt_async[0] = 1'b1;
    push_expect(32'h1);
    repeat (6) @(negedge HCLK);
    apb_read(2'd2, 32'h1, "rise0_status");
    apb_write(2'd2, 32'h1);
    apb_read(2'd2, 32'h0, "rise0_cleared");

    // Falling-edge only on line 31 after a 4-cycle high pulse.
    apb_write(2'd1, 32'h8000_0000);
    @(negedge HCLK);
    evt_async[31] = 1'b1;
    repeat (4) @(negedge HCLK);
    evt_async[31] = 1'b0;
    push_expect(32'h8000_0000);
    repeat (6) @(negedge HCLK);
    apb_read(2'd2, 32'h8000_0000, "fall31_status");
    apb_write(2'd2, 32'hFFFF_FFFF);
    apb_read(2'd2, 32'h0, "fall31_cleared");

    // Two rising edges on line 5 without clearing gives overrun.
    apb_write(2'd0, 32'h21);
    @(negedge HCLK);
    evt_async[5] = 1'b1;
    push_expect(32'h20);
    repeat (3) @(negedge HCLK);
    evt_async[5] = 1'b0;
    repeat (3) @(negedge HCLK);
    evt_async[5] = 1'b1;
    push_expect(32'h20);
    repeat (6) @(negedge HCLK);
    apb_read(2'd2, 32'h20, "ovr5_status");
    apb_read(2'd3, 32'h20, "ovr5_overrun");
    apb_write(2'd2, 32'h20);
    apb_write(2'd3, 32'h20);
    apb_read(2'd2, 32'h0, "ovr5_status_clr");
    apb_read(2'd3, 32'h0, "ovr5_overrun_clr");

    // STATUS clear racing a new hit on line 2.
    apb_write(2'd0, 32'h25);
    apb_write(2'd1, 32'h8000_0004);
    @(negedge HCLK);
    evt_async[2] = 1'b1;
    push_expect(32'h4);
    repeat (6) @(negedge HCLK);
    apb_read(2'd2, 32'h4, "race2_pre_status");
    @(negedge HCLK);
    evt_async[2] = 1'b0;
    push_expect(32'h4);
    apb_write(2'd2, 32'h4);
    repeat (4) @(negedge HCLK);
    apb_read(2'd2, 32'h4, "race2_status");
    apb_read(2'd3, 32'h0, "race2_overrun");
    apb_write(2'd2, 32'h4);

    // Toggle line 7 every 2 cycles with both edges: one pulse per toggle.
    apb_write(2'd0, 32'h80);
    apb_write(2'd1, 32'h80);
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      evt_async[7] = ~evt_async[7];
      push_expect(32'h80);
      @(negedge HCLK);
    end
    repeat (6) @(negedge HCLK);
    apb_read(2'd2, 32'h80, "toggle7_status");
    apb_read(2'd3, 32'h80, "toggle7_overrun");
    apb_write(2'd2, 32'hFFFF_FFFF);
    apb_write(2'd3, 32'hFFFF_FFFF);
    apb_read(2'd1, 32'h80, "toggle7_fall_en_kept");

    // Reset while a pulse on line 0 is in flight: pulse is dropped.
    apb_write(2'd0, 32'h1);
    @(negedge HCLK);
    evt_async[0] = 1'b0;
    repeat (3) @(negedge HCLK);
    evt_async[0] = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b1;
    #1;
    check("midrst_evt", evt, 32'h0);
    check("midrst_cnt", {30'h0, dut.warm_cnt}, 32'h0);
    apb_read(2'd0, 32'h0, "midrst_rise_en");
    apb_read(2'd2, 32'h0, "midrst_status");
    apb_read(2'd3, 32'h0, "midrst_overrun");
    release_with_rise(32'h1);
    repeat (6) @(negedge HCLK);
    apb_read(2'd2, 32'h0, "rewarm_status");
    @(negedge HCLK);
    evt_async[0] = 1'b0;
    repeat (3) @(negedge HCLK);
    evt_async[0] = 1'b1;
    push_expect(32'h1);
    repeat (6) @(negedge HCLK);
    apb_read(2'd2, 32'h1, "rewarm_rise_status");

    repeat (4) @(negedge HCLK);
    check("pulses_outstanding", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [1:0] EDGE_STATUS_IDX();
    return 2'd2;
  endfunction

endmodule
